// File: rtl/ddr_ui_arbiter_if.sv
// MIG user-interface bundle (command, write-data and read-data channels).
// The arbiter drives it through the master modport; the MIG sits on the slave side.
interface ddr_ui_arbiter_if #(
  parameter int APP_DATA_WIDTH = 64,
  parameter int APP_ADDR_WIDTH = 32,
  parameter int APP_MASK_WIDTH = 8
) ();
  logic [APP_ADDR_WIDTH-1:0] app_addr;
  logic [2:0]                app_cmd;
  logic                      app_en;
  logic [APP_DATA_WIDTH-1:0] app_wdf_data;
  logic [APP_MASK_WIDTH-1:0] app_wdf_mask;
  logic                      app_wdf_wren;
  logic                      app_wdf_end;
  logic                      app_rdy;
  logic                      app_wdf_rdy;
  logic [APP_DATA_WIDTH-1:0] app_rd_data;
  logic                      app_rd_data_valid;
  logic                      app_rd_data_end;

  modport master (
    output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
    input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end
  );

  modport slave (
    input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
    output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end
  );
endinterface

// File: rtl/ddr_ui_arbiter.sv
// Transaction-level arbiter sharing one MIG UI between NUM_REQ burst clients.
// Define ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority; default is round-robin.
module ddr_ui_arbiter #(
  parameter int APP_DATA_WIDTH = 64,
  parameter int APP_ADDR_WIDTH = 32,
  parameter int APP_MASK_WIDTH = 8,
  parameter int NUM_REQ        = 2,
  parameter int OUTS_WIDTH     = 6
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               init_calib_complete,
  input  logic [NUM_REQ-1:0]                 req,
  input  logic [NUM_REQ-1:0]                 rel,
  output logic [NUM_REQ-1:0]                 gnt,
  output logic                               busy,
  input  logic [NUM_REQ*APP_ADDR_WIDTH-1:0]  cli_app_addr,
  input  logic [NUM_REQ*3-1:0]               cli_app_cmd,
  input  logic [NUM_REQ-1:0]                 cli_app_en,
  input  logic [NUM_REQ*APP_DATA_WIDTH-1:0]  cli_app_wdf_data,
  input  logic [NUM_REQ*APP_MASK_WIDTH-1:0]  cli_app_wdf_mask,
  input  logic [NUM_REQ-1:0]                 cli_app_wdf_wren,
  input  logic [NUM_REQ-1:0]                 cli_app_wdf_end,
  output logic [NUM_REQ-1:0]                 cli_app_rdy,
  output logic [NUM_REQ-1:0]                 cli_app_wdf_rdy,
  output logic [NUM_REQ-1:0]                 cli_app_rd_data_valid,
  output logic [NUM_REQ-1:0]                 cli_app_rd_data_end,
  output logic [APP_DATA_WIDTH-1:0]          cli_app_rd_data,
  ddr_ui_arbiter_if.master                   mig
);

  localparam int IW = $clog2(NUM_REQ);
  localparam logic [OUTS_WIDTH-1:0] OUTS_MAX  = {OUTS_WIDTH{1'b1}};
  localparam logic [OUTS_WIDTH-1:0] OUTS_ZERO = {OUTS_WIDTH{1'b0}};
  localparam logic [OUTS_WIDTH-1:0] OUTS_ONE  = {{(OUTS_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [NUM_REQ-1:0]    GNT_ONE   = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OWN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [IW-1:0]           owner_q, owner_d;
  logic [IW-1:0]           ptr_q, ptr_d;
  logic [OUTS_WIDTH-1:0]   outs_q, outs_d;
  logic [NUM_REQ-1:0]      gnt_q, gnt_d;
  logic                    busy_q, busy_d;

  logic                      own_s, drain_s, act_s, outs_full_s;
  logic                      rd_acc_s, rd_ret_s;
  logic [IW-1:0]             win_s;
  logic [APP_ADDR_WIDTH-1:0] own_addr_s;
  logic [2:0]                own_cmd_s;
  logic                      own_en_s, own_wren_s, own_end_s;
  logic [APP_DATA_WIDTH-1:0] own_wdata_s;
  logic [APP_MASK_WIDTH-1:0] own_wmask_s;

`ifdef ARB_FIXED_PRIO_EN
  function automatic logic [IW-1:0] pick_winner(input logic [NUM_REQ-1:0] r,
                                                input logic [IW-1:0] p);
    logic [IW-1:0] w;
    w = {IW{1'b0}};
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (r[i]) begin
        w = IW'(i);
      end else begin
        w = w;
      end
    end
    w = w | (p & {IW{1'b0}});
    return w;
  endfunction
`else
  // Search starts one past the last winner so a just-released client goes to the back.
  function automatic logic [IW-1:0] pick_winner(input logic [NUM_REQ-1:0] r,
                                                input logic [IW-1:0] p);
    logic [IW-1:0] w;
    logic          found;
    int            idx;
    w     = {IW{1'b0}};
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(p) + i) % NUM_REQ;
      if (!found && r[idx]) begin
        w     = IW'(idx);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return w;
  endfunction
`endif

  // Owner slice extraction and state decode.
  always_comb begin
    own_s       = (state_q == S_OWN);
    drain_s     = (state_q == S_DRAIN);
    act_s       = own_s | drain_s;
    outs_full_s = (outs_q == OUTS_MAX);
    own_addr_s  = cli_app_addr[int'(owner_q)*APP_ADDR_WIDTH +: APP_ADDR_WIDTH];
    own_cmd_s   = cli_app_cmd[int'(owner_q)*3 +: 3];
    own_en_s    = cli_app_en[owner_q];
    own_wdata_s = cli_app_wdf_data[int'(owner_q)*APP_DATA_WIDTH +: APP_DATA_WIDTH];
    own_wmask_s = cli_app_wdf_mask[int'(owner_q)*APP_MASK_WIDTH +: APP_MASK_WIDTH];
    own_wren_s  = cli_app_wdf_wren[owner_q];
    own_end_s   = cli_app_wdf_end[owner_q];
  end

  // MIG-side mux: strobes only in OWN, and commands held off while the read counter is full.
  always_comb begin
    mig.app_en       = own_s & own_en_s & ~outs_full_s;
    mig.app_wdf_wren = own_s & own_wren_s;
    mig.app_wdf_end  = own_s & own_end_s;
    if (act_s) begin
      mig.app_addr     = own_addr_s;
      mig.app_cmd      = own_cmd_s;
      mig.app_wdf_data = own_wdata_s;
      mig.app_wdf_mask = own_wmask_s;
    end else begin
      mig.app_addr     = {APP_ADDR_WIDTH{1'b0}};
      mig.app_cmd      = 3'b000;
      mig.app_wdf_data = {APP_DATA_WIDTH{1'b0}};
      mig.app_wdf_mask = {APP_MASK_WIDTH{1'b0}};
    end
  end

  // Client-side return path: only the owner slice ever sees ready or read strobes.
  always_comb begin
    cli_app_rdy           = {NUM_REQ{1'b0}};
    cli_app_wdf_rdy       = {NUM_REQ{1'b0}};
    cli_app_rd_data_valid = {NUM_REQ{1'b0}};
    cli_app_rd_data_end   = {NUM_REQ{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      if (act_s && (owner_q == IW'(k))) begin
        cli_app_rdy[k]           = own_s & mig.app_rdy & ~outs_full_s;
        cli_app_wdf_rdy[k]       = own_s & mig.app_wdf_rdy;
        cli_app_rd_data_valid[k] = mig.app_rd_data_valid;
        cli_app_rd_data_end[k]   = mig.app_rd_data_end;
      end else begin
        cli_app_rdy[k]           = 1'b0;
        cli_app_wdf_rdy[k]       = 1'b0;
        cli_app_rd_data_valid[k] = 1'b0;
        cli_app_rd_data_end[k]   = 1'b0;
      end
    end
    if (act_s) begin
      cli_app_rd_data = mig.app_rd_data;
    end else begin
      cli_app_rd_data = {APP_DATA_WIDTH{1'b0}};
    end
  end

  // Outstanding-read counter; a stray return with nothing in flight is ignored.
  always_comb begin
    rd_acc_s = mig.app_en & mig.app_rdy & (own_cmd_s == 3'b001);
    rd_ret_s = mig.app_rd_data_valid & mig.app_rd_data_end;
    case ({rd_acc_s, rd_ret_s})
      2'b10: outs_d = outs_q + OUTS_ONE;
      2'b01: begin
        if (outs_q != OUTS_ZERO) begin
          outs_d = outs_q - OUTS_ONE;
        end else begin
          outs_d = outs_q;
        end
      end
      default: outs_d = outs_q;
    endcase
  end

  // Ownership FSM next-state; release leaves via DRAIN whenever reads are still in flight.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    win_s   = pick_winner(req, ptr_q);
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          state_d = S_OWN;
          owner_d = win_s;
`ifdef ARB_FIXED_PRIO_EN
          ptr_d   = ptr_q;
`else
          ptr_d   = win_s;
`endif
          gnt_d   = GNT_ONE << win_s;
        end else begin
          gnt_d   = {NUM_REQ{1'b0}};
        end
      end
      S_OWN: begin
        if (rel[owner_q]) begin
          if (outs_d == OUTS_ZERO) begin
            state_d = S_IDLE;
            gnt_d   = {NUM_REQ{1'b0}};
          end else begin
            state_d = S_DRAIN;
          end
        end else begin
          state_d = S_OWN;
        end
      end
      S_DRAIN: begin
        if (outs_d == OUTS_ZERO) begin
          state_d = S_IDLE;
          gnt_d   = {NUM_REQ{1'b0}};
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = {NUM_REQ{1'b0}};
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State registers; an uncalibrated MIG holds the arbiter in reset.
  always_ff @(posedge clk) begin
    if (rst || !init_calib_complete) begin
      state_q <= S_IDLE;
      owner_q <= {IW{1'b0}};
      ptr_q   <= IW'(NUM_REQ - 1);
      outs_q  <= OUTS_ZERO;
      gnt_q   <= {NUM_REQ{1'b0}};
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      outs_q  <= outs_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt  = gnt_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_ddr_ui_arbiter.sv
// Directed bench for ddr_ui_arbiter: calibration gating, round-robin tenures,
// isolation, read drain and outstanding-read back-pressure (OUTS_WIDTH=4, 15 max).
module tb_ddr_ui_arbiter;
  localparam int DW = 64;
  localparam int AW = 32;
  localparam int MW = 8;
  localparam int NR = 2;
  localparam int OW = 4;
`ifdef ARB_FIXED_PRIO_EN
  localparam int          SECOND_K = 0;
  localparam logic [1:0]  SECOND_G = 2'b01;
`else
  localparam int          SECOND_K = 1;
  localparam logic [1:0]  SECOND_G = 2'b10;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, calib;
  logic [NR-1:0]      req, rel, gnt;
  logic               busy;
  logic [NR*AW-1:0]   cli_addr;
  logic [NR*3-1:0]    cli_cmd;
  logic [NR-1:0]      cli_en, cli_wren, cli_wend;
  logic [NR*DW-1:0]   cli_wdata;
  logic [NR*MW-1:0]   cli_mask;
  logic [NR-1:0]      cli_rdy, cli_wrdy, cli_rv, cli_rend;
  logic [DW-1:0]      cli_rdata;
  logic               app_rdy_tb, app_wdf_rdy_tb, mig_ret_en, man_v;
  logic [9:0]         pv;
  logic [DW-1:0]      pd [10];
  int                 n_chk = 0;
  int                 n_fail = 0;
  int                 acc_cnt, wren_cnt;
  int                 snap, rv_cnt;
  logic               acc;

  ddr_ui_arbiter_if #(.APP_DATA_WIDTH(DW), .APP_ADDR_WIDTH(AW), .APP_MASK_WIDTH(MW)) mig ();

  ddr_ui_arbiter #(
    .APP_DATA_WIDTH(DW), .APP_ADDR_WIDTH(AW), .APP_MASK_WIDTH(MW),
    .NUM_REQ(NR), .OUTS_WIDTH(OW)
  ) dut (
    .clk(clk), .rst(rst), .init_calib_complete(calib),
    .req(req), .rel(rel), .gnt(gnt), .busy(busy),
    .cli_app_addr(cli_addr), .cli_app_cmd(cli_cmd), .cli_app_en(cli_en),
    .cli_app_wdf_data(cli_wdata), .cli_app_wdf_mask(cli_mask),
    .cli_app_wdf_wren(cli_wren), .cli_app_wdf_end(cli_wend),
    .cli_app_rdy(cli_rdy), .cli_app_wdf_rdy(cli_wrdy),
    .cli_app_rd_data_valid(cli_rv), .cli_app_rd_data_end(cli_rend),
    .cli_app_rd_data(cli_rdata),
    .mig(mig)
  );

  // MIG model: fixed 10-cycle read latency, data = {D0000000, address}
  assign mig.app_rdy           = app_rdy_tb;
  assign mig.app_wdf_rdy       = app_wdf_rdy_tb;
  assign mig.app_rd_data_valid = pv[9] | man_v;
  assign mig.app_rd_data_end   = pv[9] | man_v;
  assign mig.app_rd_data       = pd[9];
  assign acc = mig.app_en & mig.app_rdy & (mig.app_cmd == 3'b001);

  always @(posedge clk) begin
    if (rst) begin
      pv       <= 10'd0;
      acc_cnt  <= 0;
      wren_cnt <= 0;
    end else begin
      pv <= {pv[8:0], mig_ret_en & acc};
      if (acc) acc_cnt <= acc_cnt + 1;
      if (mig.app_wdf_wren) wren_cnt <= wren_cnt + 1;
    end
    pd[0] <= {32'hD000_0000, mig.app_addr};
    for (int i = 1; i < 10; i++) pd[i] <= pd[i-1];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_writes(input int k, input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      cli_addr[k*AW +: AW]  = base + 32'(i);
      cli_cmd[k*3 +: 3]     = 3'b000;
      cli_wdata[k*DW +: DW] = {32'hA5A5_0000, base + 32'(i)};
      cli_en[k]   = 1'b1;
      cli_wren[k] = 1'b1;
      cli_wend[k] = 1'b1;
      #1;
      chk("wr_addr", 64'(mig.app_addr), 64'(base + 32'(i)));
      chk("wr_data", mig.app_wdf_data, {32'hA5A5_0000, base + 32'(i)});
      chk("wr_rdy", 64'(cli_rdy[k]), 64'd1);
      chk("wr_wdf_rdy", 64'(cli_wrdy[k]), 64'd1);
      tick;
    end
    cli_en[k]   = 1'b0;
    cli_wren[k] = 1'b0;
    cli_wend[k] = 1'b0;
  endtask

  task automatic rel_pulse(input int k);
    rel[k] = 1'b1;
    tick;
    rel[k] = 1'b0;
  endtask

  initial begin
    rst = 1'b1; calib = 1'b0; req = '0; rel = '0;
    cli_addr = '0; cli_cmd = '0; cli_en = '0; cli_wren = '0; cli_wend = '0;
    cli_wdata = '0; cli_mask = '0;
    app_rdy_tb = 1'b1; app_wdf_rdy_tb = 1'b1; mig_ret_en = 1'b1; man_v = 1'b0;
    repeat (3) tick;
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_app_en", 64'(mig.app_en), 64'd0);
    chk("rst_app_addr", 64'(mig.app_addr), 64'd0);
    chk("rst_cli_rdy", 64'(cli_rdy), 64'd0);

    // calibration low acts as reset
    rst = 1'b0; req = 2'b11;
    repeat (3) tick;
    chk("calib_gnt", 64'(gnt), 64'd0);
    chk("calib_app_en", 64'(mig.app_en), 64'd0);
    calib = 1'b1;
    tick;
    chk("first_gnt", 64'(gnt), 64'h1);
    chk("first_busy", 64'(busy), 64'd1);

    // round-robin tenures
    snap = wren_cnt;
    do_writes(0, 4, 32'h100);
    chk("wren_cnt0", 64'(wren_cnt - snap), 64'd4);
    rel_pulse(0);
    chk("rel0_gnt", 64'(gnt), 64'd0);
    tick;
    chk("second_gnt", 64'(gnt), 64'(SECOND_G));
    snap = wren_cnt;
    do_writes(SECOND_K, 4, 32'h200);
    chk("wren_cnt1", 64'(wren_cnt - snap), 64'd4);
    rel_pulse(SECOND_K);
    chk("rel1_gnt", 64'(gnt), 64'd0);
    tick;
    chk("third_gnt", 64'(gnt), 64'h1);

    // isolation: client 1 toggles strobes while client 0 owns and is silent
    cli_addr[AW-1:0] = 32'h0;
    cli_addr[2*AW-1:AW] = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      cli_en[1]   = (i % 2 == 0);
      cli_wren[1] = (i % 2 == 0);
      cli_wend[1] = (i % 2 == 0);
      #1;
      chk("iso_app_en", 64'(mig.app_en), 64'd0);
      chk("iso_wren", 64'(mig.app_wdf_wren), 64'd0);
      chk("iso_addr", 64'(mig.app_addr), 64'd0);
      chk("iso_rdy1", 64'(cli_rdy[1]), 64'd0);
      tick;
    end
    cli_en[1] = 1'b0; cli_wren[1] = 1'b0; cli_wend[1] = 1'b0;

    // drain: 8 reads, release right after the last command
    req = 2'b01;
    cli_cmd[2:0] = 3'b001;
    for (int i = 0; i < 8; i++) begin
      cli_addr[AW-1:0] = 32'h300 + 32'(i);
      cli_en[0] = 1'b1;
      tick;
    end
    cli_en[0] = 1'b0;
    rel_pulse(0);
    chk("drain_busy", 64'(busy), 64'd1);
    chk("drain_gnt_hold", 64'(gnt), 64'h1);
    chk("drain_cli_rdy", 64'(cli_rdy), 64'd0);
    cli_en[0] = 1'b1;
    #1;
    chk("drain_app_en", 64'(mig.app_en), 64'd0);
    cli_en[0] = 1'b0;
    rv_cnt = 0;
    for (int i = 0; i < 40 && rv_cnt < 8; i++) begin
      if (cli_rv[0]) begin
        chk("drain_data", cli_rdata, {32'hD000_0000, 32'h300 + 32'(rv_cnt)});
        rv_cnt++;
      end
      chk("drain_rv1", 64'(cli_rv[1]), 64'd0);
      chk("drain_gnt", 64'(gnt), 64'h1);
      tick;
    end
    chk("drain_count", 64'(rv_cnt), 64'd8);
    chk("drain_end_gnt", 64'(gnt), 64'd0);
    chk("drain_end_busy", 64'(busy), 64'd0);
    tick;
    chk("regrant_gnt", 64'(gnt), 64'h1);

    // back-pressure: 17 read attempts with no returns, counter saturates at 15
    mig_ret_en = 1'b0;
    snap = acc_cnt;
    cli_addr[AW-1:0] = 32'h400;
    cli_en[0] = 1'b1;
    repeat (17) tick;
    chk("bp_accepted", 64'(acc_cnt - snap), 64'd15);
    chk("bp_rdy_low", 64'(cli_rdy[0]), 64'd0);
    chk("bp_app_en_low", 64'(mig.app_en), 64'd0);
    man_v = 1'b1;
    tick;
    man_v = 1'b0;
    chk("bp_reenable_en", 64'(mig.app_en), 64'd1);
    chk("bp_reenable_rdy", 64'(cli_rdy[0]), 64'd1);
    tick;
    chk("bp_accepted2", 64'(acc_cnt - snap), 64'd16);
    chk("bp_full_again", 64'(cli_rdy[0]), 64'd0);
    cli_en[0] = 1'b0;
    req = 2'b00;
    rel_pulse(0);
    chk("bp_drain_busy", 64'(busy), 64'd1);
    man_v = 1'b1;
    repeat (15) tick;
    man_v = 1'b0;
    chk("bp_final_gnt", 64'(gnt), 64'd0);
    chk("bp_final_busy", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
